i2c_master_ctrl: RTL and testbench

//  Byte-level I2C master: START, repeated START, address/data write with ACK check,

---
 rtl/i2c_master_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_ctrl.sv
// Byte-level I2C master: START / repeated START, 8-bit write or read with a ninth ACK bit, STOP.
// Open-drain SDA/SCL, quarter-period timing, optional slave clock stretching.
//
// state | meaning
// IDLE  | bus released, waiting for a command
// START | (repeated) START condition, 4 quarters
// BIT   | 9 bit slots of 4 quarters each (8 data + ACK)
// STOP  | STOP condition, 4 quarters
// HOLD  | byte done without STOP, SCL held low, waiting for the next command
module i2c_master_ctrl #(
    parameter int CLK_DIV = 10000,
    parameter int STRETCH = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_start,
    input  logic       cmd_stop,
    input  logic       cmd_read,
    input  logic       cmd_nack,
    input  logic [7:0] wdata,
    output logic       rsp_valid,
    output logic [7:0] rdata,
    output logic       rsp_nack,
    output logic       busy,
    inout  wire        SDA,
    inout  wire        SCL
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_BIT   = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    localparam int Q  = CLK_DIV / 4;
    localparam int QW = (Q > 1) ? $clog2(Q) : 1;
    localparam logic [QW-1:0] Q_LAST = QW'(Q - 1);

    logic [2:0]    state, state_n;
    logic [1:0]    phase, phase_n;
    logic [3:0]    bit_idx, bit_n;
    logic [QW-1:0] q_cnt;
    logic          c_stop, c_read, c_nack;
    logic          stop_n, read_n, nack_n;
    logic [7:0]    tx, tx_n;
    logic [7:0]    rx;
    logic          ack_bit;
    logic          scl_oe, sda_oe, scl_oe_n, sda_oe_n;
    logic          sda_in, scl_in;
    logic          active, stretch_ph, stall, q_end, accept, sample, done;
    logic          bit_drv, ack_drv;

    assign SDA    = sda_oe ? 1'b0 : 1'bz;
    assign SCL    = scl_oe ? 1'b0 : 1'bz;
    assign sda_in = SDA;
    assign scl_in = SCL;

    assign active = (state == S_START) || (state == S_BIT) || (state == S_STOP);

    // Phases where SCL has been released and a slave may still be holding it low.
    always_comb begin
        stretch_ph = 1'b0;
        case (state)
            S_BIT:           stretch_ph = (phase == 2'd1) || (phase == 2'd2);
            S_START, S_STOP: stretch_ph = (phase == 2'd1);
            default:         stretch_ph = 1'b0;
        endcase
    end

    assign stall  = (STRETCH != 0) && stretch_ph && !scl_oe && !scl_in;
    assign q_end  = active && !stall && (q_cnt == Q_LAST);
    assign accept = cmd_valid && cmd_ready;
    assign sample = q_end && (state == S_BIT) && (phase == 2'd2);

    assign stop_n = accept ? cmd_stop : c_stop;
    assign read_n = accept ? cmd_read : c_read;
    assign nack_n = accept ? cmd_nack : c_nack;
    assign tx_n   = accept ? wdata    : tx;

    always_comb begin
        state_n = state;
        phase_n = phase;
        bit_n   = bit_idx;
        if (accept) begin
            phase_n = 2'd0;
            bit_n   = 4'd0;
            state_n = (state == S_IDLE || cmd_start) ? S_START : S_BIT;
        end else if (q_end) begin
            phase_n = phase + 2'd1;
            if (phase == 2'd3) begin
                case (state)
                    S_START: begin
                        state_n = S_BIT;
                        bit_n   = 4'd0;
                    end
                    S_BIT: begin
                        if (bit_idx == 4'd8) state_n = c_stop ? S_STOP : S_HOLD;
                        else                 bit_n   = bit_idx + 4'd1;
                    end
                    S_STOP:  state_n = S_IDLE;
                    default: state_n = S_IDLE;
                endcase
            end
        end
    end

    assign done = ((state_n == S_HOLD) || (state_n == S_IDLE)) &&
                  ((state == S_BIT) || (state == S_STOP));

    // Pad enables are registered from the next state so the pins never glitch.
    always_comb begin
        scl_oe_n = 1'b0;
        sda_oe_n = 1'b0;
        bit_drv  = !read_n && !tx_n[3'd7 - bit_n[2:0]];
        ack_drv  = read_n && !nack_n;
        case (state_n)
            S_START: begin
                case (phase_n)
                    2'd0:    scl_oe_n = scl_oe;
                    2'd1:    scl_oe_n = 1'b0;
                    2'd2:    sda_oe_n = 1'b1;
                    default: begin
                        sda_oe_n = 1'b1;
                        scl_oe_n = 1'b1;
                    end
                endcase
            end
            S_BIT: begin
                sda_oe_n = (bit_n == 4'd8) ? ack_drv : bit_drv;
                scl_oe_n = (phase_n == 2'd0) || (phase_n == 2'd3);
            end
            S_STOP: begin
                sda_oe_n = (phase_n == 2'd0) || (phase_n == 2'd1);
                scl_oe_n = (phase_n == 2'd0);
            end
            S_HOLD: begin
                scl_oe_n = 1'b1;
                sda_oe_n = ack_drv;
            end
            default: begin
                scl_oe_n = 1'b0;
                sda_oe_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            phase     <= 2'd0;
            bit_idx   <= 4'd0;
            q_cnt     <= '0;
            c_stop    <= 1'b0;
            c_read    <= 1'b0;
            c_nack    <= 1'b0;
            tx        <= 8'd0;
            rx        <= 8'd0;
            ack_bit   <= 1'b0;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rdata     <= 8'd0;
            rsp_nack  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            bit_idx <= bit_n;
            c_stop  <= stop_n;
            c_read  <= read_n;
            c_nack  <= nack_n;
            tx      <= tx_n;
            scl_oe  <= scl_oe_n;
            sda_oe  <= sda_oe_n;

            if (!active || q_end) q_cnt <= '0;
            else if (!stall)      q_cnt <= q_cnt + 1'b1;

            if (sample) begin
                if (bit_idx[3]) ack_bit <= sda_in;
                else            rx      <= {rx[6:0], sda_in};
            end

            rsp_valid <= done;
            if (done) begin
                if (c_read) rdata <= rx;
                rsp_nack <= !c_read && ack_bit;
            end

            busy      <= (state_n != S_IDLE);
            cmd_ready <= (state_n == S_IDLE) || (state_n == S_HOLD);
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: bus monitor + simple slave model, scoreboard of expected bytes.
module tb_i2c_master_ctrl;

    localparam int CLK_DIV = 40;
    localparam int Q       = CLK_DIV / 4;
    localparam int M_NONE  = 0;
    localparam int M_ACK   = 1;
    localparam int M_RD    = 2;

    typedef struct {
        logic [8:0] bits;
        logic       nack;
        logic [7:0] rd;
        logic       is_rd;
        string      tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_start, cmd_stop, cmd_read, cmd_nack;
    logic [7:0] wdata, rdata;
    logic       rsp_valid, rsp_nack, busy;
    wire        sda_w, scl_w;

    logic       slv_sda = 1'b0;
    logic       slv_scl = 1'b0;
    int         slave_mode = M_NONE;
    logic [7:0] slave_byte = 8'h00;

    exp_t       sb_q[$];
    logic       obs[$];
    int         fall_t[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         rsp_seen = 0;
    int         rsp_target = 0;
    int         start_cnt = 0;
    int         stop_cnt = 0;
    logic       stretch_arm = 1'b0;
    int         hold_left = 0;

    pullup (sda_w);
    pullup (scl_w);
    assign sda_w = slv_sda ? 1'b0 : 1'bz;
    assign scl_w = slv_scl ? 1'b0 : 1'bz;

    i2c_master_ctrl #(.CLK_DIV(CLK_DIV), .STRETCH(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_start (cmd_start),
        .cmd_stop  (cmd_stop),
        .cmd_read  (cmd_read),
        .cmd_nack  (cmd_nack),
        .wdata     (wdata),
        .rsp_valid (rsp_valid),
        .rdata     (rdata),
        .rsp_nack  (rsp_nack),
        .busy      (busy),
        .SDA       (sda_w),
        .SCL       (scl_w)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Bus monitor and slave: decodes START/STOP/bits, ACKs or returns a byte, stretches SCL on request.
    initial begin
        logic scl_p, sda_p, cond, rd_done;
        int   bitn;
        scl_p = 1'b1; sda_p = 1'b1; cond = 1'b1; rd_done = 1'b0; bitn = 0;
        forever begin
            @(negedge clk);
            if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) slv_scl = 1'b0;
            end
            if (scl_w === 1'b1 && scl_p === 1'b0) begin
                cond = 1'b0;
            end else if (scl_w === 1'b1 && scl_p === 1'b1 && sda_w !== sda_p) begin
                cond = 1'b1;
                if (sda_w === 1'b0) begin
                    start_cnt++;
                    bitn    = 0;
                    rd_done = 1'b0;
                end else begin
                    stop_cnt++;
                    slv_sda = 1'b0;
                end
            end else if (scl_w === 1'b0 && scl_p === 1'b1) begin
                fall_t.push_back(cyc);
                if (!cond) begin
                    obs.push_back(sda_w);
                    if (bitn == 8) begin
                        bitn = 0;
                        if (slave_mode == M_RD) rd_done = 1'b1;
                    end else begin
                        bitn++;
                    end
                end
                slv_sda = 1'b0;
                if (slave_mode == M_ACK && bitn == 8) slv_sda = 1'b1;
                if (slave_mode == M_RD && !rd_done && bitn < 8) slv_sda = !slave_byte[3'(7 - bitn)];
                if (stretch_arm && fall_t.size() == 3) begin
                    stretch_arm = 1'b0;
                    slv_scl     = 1'b1;
                    hold_left   = 2 * Q + 50;
                end
            end
            scl_p = scl_w;
            sda_p = sda_w;
        end
    end

    // Scoreboard: every rsp_valid pulse must match the oldest outstanding command.
    initial begin
        exp_t       e;
        logic [8:0] obs_v;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                rsp_seen++;
                checks++;
                assert (sb_q.size() > 0) else begin
                    errors++;
                    $error("FAIL rsp_unexpected observed=pulse expected=none");
                end
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk({e.tag, "_nbits"}, obs.size(), 9);
                    obs_v = '1;
                    for (int i = 0; i < 9; i++)
                        if (obs.size() > 0) obs_v = {obs_v[7:0], obs.pop_front()};
                    chk({e.tag, "_bits"}, {23'd0, obs_v}, {23'd0, e.bits});
                    if (e.is_rd) chk({e.tag, "_rdata"}, {24'd0, rdata}, {24'd0, e.rd});
                    else         chk({e.tag, "_nack"}, {31'd0, rsp_nack}, {31'd0, e.nack});
                end
            end
        end
    end

    task automatic issue(input logic st, input logic sp, input logic rd, input logic nk,
                         input logic [7:0] wd, input logic [8:0] ebits, input logic enack,
                         input logic [7:0] erd, input string tag);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
        cmd_start = st; cmd_stop = sp; cmd_read = rd; cmd_nack = nk; wdata = wd;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_start = ~st; cmd_stop = ~sp; cmd_read = ~rd; cmd_nack = ~nk; wdata = ~wd;
        e.bits = ebits; e.nack = enack; e.rd = erd; e.is_rd = rd; e.tag = tag;
        sb_q.push_back(e);
        rsp_target = rsp_seen + 1;
    endtask

    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        while (rsp_seen < rsp_target && n < 1500) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rsp_in_time"}, rsp_seen, rsp_target);
    endtask

    initial begin
        int s0, p0, r0, n;
        rst = 1'b1; cmd_valid = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0;
        cmd_read = 1'b0; cmd_nack = 1'b0; wdata = 8'h00;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_sda", {31'd0, sda_w}, 32'd1);
        chk("rst_scl", {31'd0, scl_w}, 32'd1);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata", {24'd0, rdata}, 32'd0);
        chk("rst_rsp_nack", {31'd0, rsp_nack}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // Two-byte write, START forced from IDLE even without cmd_start.
        slave_mode = M_ACK;
        s0 = start_cnt; p0 = stop_cnt;
        issue(1'b0, 1'b0, 1'b0, 1'b0, 8'hA0, {8'hA0, 1'b0}, 1'b0, 8'h00, "t1_b0");
        wait_rsp("t1_b0");
        chk("t1_start_forced", start_cnt - s0, 1);
        chk("t1_busy_hold", {31'd0, busy}, 32'd1);
        issue(1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, {8'h3C, 1'b0}, 1'b0, 8'h00, "t1_b1");
        wait_rsp("t1_b1");
        chk("t1_stop_seen", stop_cnt - p0, 1);
        chk("t1_no_restart", start_cnt - s0, 1);
        chk("t1_busy_end", {31'd0, busy}, 32'd0);

        // No slave: NACK reported, STOP still generated.
        slave_mode = M_NONE;
        p0 = stop_cnt;
        issue(1'b1, 1'b1, 1'b0, 1'b0, 8'hA0, {8'hA0, 1'b1}, 1'b1, 8'h00, "t2");
        wait_rsp("t2");
        chk("t2_stop_seen", stop_cnt - p0, 1);
        chk("t2_busy_end", {31'd0, busy}, 32'd0);

        // Read with NACK and STOP.
        slave_mode = M_RD; slave_byte = 8'h5A;
        p0 = stop_cnt;
        issue(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, {8'h5A, 1'b1}, 1'b0, 8'h5A, "t3");
        wait_rsp("t3");
        chk("t3_stop_seen", stop_cnt - p0, 1);

        // Write without STOP, then repeated START into a read that ACKs.
        slave_mode = M_ACK;
        p0 = stop_cnt;
        issue(1'b1, 1'b0, 1'b0, 1'b0, 8'hA0, {8'hA0, 1'b0}, 1'b0, 8'h00, "t4_wr");
        wait_rsp("t4_wr");
        slave_mode = M_RD; slave_byte = 8'hC3;
        s0 = start_cnt;
        issue(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, {8'hC3, 1'b0}, 1'b0, 8'hC3, "t4_rd");
        n = 0;
        while (start_cnt == s0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t4_rstart_seen", start_cnt - s0, 1);
        chk("t4_busy_rstart", {31'd0, busy}, 32'd1);
        chk("t4_no_stop_between", stop_cnt - p0, 0);
        wait_rsp("t4_rd");
        chk("t4_stop_seen", stop_cnt - p0, 1);

        // Slave stretches bit 3 by 50 clocks from the start of its q1.
        slave_mode = M_ACK;
        fall_t.delete();
        stretch_arm = 1'b1;
        issue(1'b1, 1'b1, 1'b0, 1'b0, 8'hA0, {8'hA0, 1'b0}, 1'b0, 8'h00, "t5");
        wait_rsp("t5");
        chk("t5_nfalls", {31'd0, fall_t.size() >= 4}, 32'd1);
        if (fall_t.size() >= 4) begin
            chk("t5_nominal_bit", fall_t[2] - fall_t[1], 4 * Q);
            chk("t5_stretched_bit", fall_t[3] - fall_t[2], 4 * Q + 50);
        end

        // Reset in the middle of bit 5: bus released next cycle, byte never completes.
        slave_mode = M_NONE;
        fall_t.delete();
        issue(1'b1, 1'b1, 1'b0, 1'b0, 8'h55, {8'h55, 1'b1}, 1'b1, 8'h00, "t6");
        n = 0;
        while (fall_t.size() < 5 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("t6_reached_bit5", {31'd0, fall_t.size() >= 5}, 32'd1);
        repeat (Q + 3) @(negedge clk);
        r0 = rsp_seen;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("t6_sda_released", {31'd0, sda_w}, 32'd1);
        chk("t6_scl_released", {31'd0, scl_w}, 32'd1);
        chk("t6_ready", {31'd0, cmd_ready}, 32'd1);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        sb_q.delete();
        obs.delete();
        repeat (20 * Q) @(negedge clk);
        chk("t6_no_rsp", rsp_seen - r0, 0);

        // Normal traffic after the abort.
        slave_mode = M_ACK;
        p0 = stop_cnt;
        obs.delete();
        issue(1'b1, 1'b1, 1'b0, 1'b0, 8'h96, {8'h96, 1'b0}, 1'b0, 8'h00, "t7");
        wait_rsp("t7");
        chk("t7_stop_seen", stop_cnt - p0, 1);

        repeat (10) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
